// File: rtl/event_encoder_pkg.sv
// rtl/event_encoder_pkg.sv - shared constants and width helper for event_encoder
// Contents:
//   MODE_FIXED / MODE_RR  selection policy codes for the RR_MODE parameter
//   idx_width(n)          max(1, clog2(n)), width of an encoded request index
package event_encoder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int idx_width(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/event_encoder_prio_pick.sv
// rtl/event_encoder_prio_pick.sv - combinational wrapping first-set search
// Ports:
//   vec    in   N  candidate bits
//   start  in   W  index where the search begins; wraps modulo N
//   found  out  1  some bit of vec is set
//   idx    out  W  first set index at or above start (0 when none found)
module prio_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  int           j;
  logic [N-1:0] sh;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    sh    = '0;
    for (int off = 0; off < N; off++) begin
      j = int'(start) + off;
      if (j >= N) j = j - N;
      // Shift instead of bit-select so the candidate index keeps its natural width.
      sh = vec >> j;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/event_encoder.sv
// rtl/event_encoder.sv - event collector and priority/round-robin index encoder
// Ports:
//   clk        in   1  clock, all state on rising edge
//   rst        in   1  asynchronous active-high reset
//   req        in   N  event lines, a high sample is one event
//   ovf_clr    in   1  synchronous clear of the overflow flag
//   out_ready  in   1  consumer accepts out_idx
//   out_valid  out  1  out_idx holds an encoded event
//   out_idx    out  W  index of the issued event
//   pend_any   out  1  registered OR of the pending register
//   overflow   out  1  sticky: an event merged into an already-pending bit
module event_encoder
  import event_encoder_pkg::*;
#(
  parameter int  N       = 8,
  parameter int  RR_MODE = MODE_FIXED,
  localparam int W       = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ovf_clr,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         pend_any,
  output logic         overflow
);

  logic [N-1:0] pending;
  logic [N-1:0] take_mask;
  logic [N-1:0] pending_nxt;
  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic [W-1:0] sel;
  logic         found;
  logic         load;
  logic         collide;

  // Fixed priority is just a wrapping search that always begins at 0.
  assign start = (RR_MODE == MODE_RR) ? ptr : '0;

  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .vec   (pending),
    .start (start),
    .found (found),
    .idx   (sel)
  );

  assign load      = !out_valid || out_ready;
  assign take_mask = (load && found) ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
  // OR-ing req after the clear makes a same-edge request win over the take.
  assign pending_nxt = (pending & ~take_mask) | req;
  assign collide     = |(req & pending & ~take_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      pend_any  <= 1'b0;
      overflow  <= 1'b0;
      ptr       <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_any <= |pending_nxt;
      overflow <= collide | (overflow & ~ovf_clr);
      if (load) begin
        out_valid <= found;
        if (found) out_idx <= sel;
      end
      if (RR_MODE == MODE_RR && load && found)
        ptr <= (sel == W'(N - 1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: tb/tb_event_encoder.sv
// tb/tb_event_encoder.sv - directed self-checking bench for event_encoder
module tb_event_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       ovf_clr = 1'b0;
  logic       out_ready = 1'b0;

  logic       f_valid, f_pend, f_ovf;
  logic [2:0] f_idx;
  logic       r_valid, r_pend, r_ovf;
  logic [2:0] r_idx;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  event_encoder #(.N(8), .RR_MODE(0)) f_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ovf_clr   (ovf_clr),
    .out_ready (out_ready),
    .out_valid (f_valid),
    .out_idx   (f_idx),
    .pend_any  (f_pend),
    .overflow  (f_ovf)
  );

  event_encoder #(.N(8), .RR_MODE(1)) r_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ovf_clr   (ovf_clr),
    .out_ready (out_ready),
    .out_valid (r_valid),
    .out_idx   (r_idx),
    .pend_any  (r_pend),
    .overflow  (r_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tick;
    tick;
    chk("rst_f_valid", f_valid, 0);
    chk("rst_f_idx", f_idx, 0);
    chk("rst_f_pend", f_pend, 0);
    chk("rst_f_ovf", f_ovf, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_pend", r_pend, 0);
    rst = 1'b0;

    // fixed priority: 1010_0100 -> 2,5,7
    out_ready = 1'b1;
    req = 8'b1010_0100;
    tick;
    req = 8'h00;
    chk("fx_first_valid", f_valid, 0);
    chk("fx_first_pend", f_pend, 1);
    tick;
    chk("fx_v0", f_valid, 1);
    chk("fx_i0", f_idx, 2);
    tick;
    chk("fx_i1", f_idx, 5);
    tick;
    chk("fx_i2", f_idx, 7);
    chk("fx_pend_last", f_pend, 0);
    tick;
    chk("fx_done_valid", f_valid, 0);
    chk("fx_done_pend", f_pend, 0);
    chk("fx_hold_idx", f_idx, 7);

    // round robin: FF held 10 edges
    req = 8'hFF;
    for (int e = 1; e <= 11; e++) begin
      if (e == 11) req = 8'h00;
      tick;
      if (e == 1) begin
        chk("rr_e1_valid", r_valid, 0);
        chk("rr_e1_ovf", r_ovf, 0);
      end else begin
        chk("rr_valid", r_valid, 1);
        chk("rr_idx", r_idx, (e - 2) % 8);
        chk("rr_ovf", r_ovf, 1);
        chk("fx_ff_idx", f_idx, 0);
      end
    end
    for (int i = 0; i < 12; i++) tick;
    chk("drain_r_valid", r_valid, 0);
    chk("drain_f_valid", f_valid, 0);
    chk("ovf_sticky_r", r_ovf, 1);
    chk("ovf_sticky_f", f_ovf, 1);

    // overflow clear without collision
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    chk("ovf_clr_r", r_ovf, 0);
    chk("ovf_clr_f", f_ovf, 0);

    // backpressure on req[3]
    out_ready = 1'b0;
    req = 8'h08;
    tick;
    req = 8'h00;
    chk("bp_e1_valid", f_valid, 0);
    tick;
    chk("bp_load_valid", f_valid, 1);
    chk("bp_load_idx", f_idx, 3);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_stall_valid", f_valid, 1);
      chk("bp_stall_idx", f_idx, 3);
    end
    out_ready = 1'b1;
    tick;
    chk("bp_accept_valid", f_valid, 0);
    chk("bp_accept_idx", f_idx, 3);
    tick;
    chk("bp_no_dup", f_valid, 0);

    // collision coinciding with ovf_clr keeps overflow set
    out_ready = 1'b0;
    req = 8'h02;
    tick;
    tick;
    chk("co_valid", f_valid, 1);
    chk("co_idx", f_idx, 1);
    chk("co_setwin_ovf", f_ovf, 0);
    ovf_clr = 1'b1;
    tick;
    chk("co_ovf_wins", f_ovf, 1);
    req = 8'h00;
    tick;
    ovf_clr = 1'b0;
    chk("co_ovf_cleared", f_ovf, 0);
    out_ready = 1'b1;
    tick;
    chk("co_drain_idx", f_idx, 1);
    chk("co_drain_valid", f_valid, 1);
    tick;
    chk("co_drain_done", f_valid, 0);

    // set wins on req[4]
    req = 8'h10;
    tick;
    tick;
    req = 8'h00;
    chk("sw_first_valid", f_valid, 1);
    chk("sw_first_idx", f_idx, 4);
    tick;
    chk("sw_second_valid", f_valid, 1);
    chk("sw_second_idx", f_idx, 4);
    tick;
    chk("sw_done_valid", f_valid, 0);
    chk("sw_ovf", f_ovf, 0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    req = 8'h0F;
    tick;
    tick;
    chk("pre_rst_valid", f_valid, 1);
    chk("pre_rst_pend", f_pend, 1);
    chk("pre_rst_ovf", f_ovf, 1);
    req = 8'hFF;
    rst = 1'b1;
    #1;
    chk("async_valid", f_valid, 0);
    chk("async_idx", f_idx, 0);
    chk("async_pend", f_pend, 0);
    chk("async_ovf", f_ovf, 0);
    tick;
    chk("rst_ignore_pend", f_pend, 0);
    rst = 1'b0;
    req = 8'h40;
    tick;
    req = 8'h00;
    chk("post_rst_e1_valid", f_valid, 0);
    chk("post_rst_e1_pend", f_pend, 1);
    tick;
    chk("post_rst_valid", f_valid, 1);
    chk("post_rst_idx", f_idx, 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
